// File: rtl/async_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// async_sram_responder_pkg
// Shared definitions for the async SRAM responder: the FSM state encoding, the
// packed view of the active-low strobe pins, the byte-lane width and helpers
// that map the lane enables onto strobes and per-bit DQ output enables.
// -----------------------------------------------------------------------------
package async_sram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_REQ  = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_e;

    localparam int LANE_W = 8;

    // Strobe pins as seen on the pads, all active-low.
    typedef struct packed {
        logic cs_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
    } strobe_t;

    localparam int      STROBE_W    = $bits(strobe_t);
    // Every strobe deasserted: this is what the pins look like with no host activity.
    localparam strobe_t STROBE_IDLE = '{default: 1'b1};

    // Active-high byte strobes {ub, lb} from the active-low lane enables.
    function automatic logic [1:0] lane_strb(input logic ub_n, input logic lb_n);
        return {~ub_n, ~lb_n};
    endfunction

    // Per-bit DQ output enable: upper byte follows ub_n, lower byte follows lb_n.
    function automatic logic [2*LANE_W-1:0] lane_oe(input logic ub_n, input logic lb_n);
        return {{LANE_W{~ub_n}}, {LANE_W{~lb_n}}};
    endfunction

endpackage

// File: rtl/async_sram_responder_sync.sv
// -----------------------------------------------------------------------------
// async_sram_responder_sync
// WIDTH-bit, STAGES-deep flop synchroniser for pad inputs. All stages reset to
// RST_VAL so the downstream logic sees a quiet bus until the chain refills.
// Ports:
//   clk  in  1      sampling clock
//   rst  in  1      asynchronous, active-high reset
//   d    in  WIDTH  asynchronous pad value
//   q    out WIDTH  synchronised value, STAGES clk later
// -----------------------------------------------------------------------------
module async_sram_responder_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: this flop array is reset like any other register (it is a few
    // flops, not a RAM); leaving it unreset would let a stale pin value fire a
    // spurious write edge straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/async_sram_responder.sv
// -----------------------------------------------------------------------------
// async_sram_responder
// Target side of the async SRAM pin protocol. Oversamples the SRAM pins into
// clk, turns write pulses and read windows into requests on a single-
// outstanding synchronous memory port, and drives DQ back on reads.
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   padin_sram_*               A, DQ and active-low strobes from the pads
//   padout_sram_dq             DQ drive value (registered read data)
//   padoe_sram_dq              per-bit DQ output enable
//   mem_valid/ready            request handshake
//   mem_write/addr/wdata/wstrb request fields, stable while valid && !ready
//   mem_rvalid/rdata           read data return, one-cycle pulse
//   err_overrun                sticky: a write edge arrived while busy
// -----------------------------------------------------------------------------
module async_sram_responder
    import async_sram_responder_pkg::*;
#(
    parameter int N_SRAM_A    = 18,
    parameter int N_SRAM_DQ   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRAM_A-1:0]  padin_sram_a,
    input  logic [N_SRAM_DQ-1:0] padin_sram_dq,
    input  logic                 padin_sram_cs_n,
    input  logic                 padin_sram_oe_n,
    input  logic                 padin_sram_we_n,
    input  logic                 padin_sram_ub_n,
    input  logic                 padin_sram_lb_n,
    output logic [N_SRAM_DQ-1:0] padout_sram_dq,
    output logic [N_SRAM_DQ-1:0] padoe_sram_dq,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_write,
    output logic [N_SRAM_A-1:0]  mem_addr,
    output logic [N_SRAM_DQ-1:0] mem_wdata,
    output logic [1:0]           mem_wstrb,
    input  logic                 mem_rvalid,
    input  logic [N_SRAM_DQ-1:0] mem_rdata,
    output logic                 err_overrun
);

    if (N_SRAM_DQ != 2 * LANE_W) begin : g_width_check
        $error("async_sram_responder: N_SRAM_DQ must be two byte lanes");
    end

    localparam int DATA_W = N_SRAM_A + N_SRAM_DQ;

    // ---------------------------------------------------------------- syncs
    strobe_t             strobe_pin;
    strobe_t             strobe_s;
    logic [DATA_W-1:0]   data_s;
    logic [N_SRAM_A-1:0] a_s;
    logic [N_SRAM_DQ-1:0] dq_s;

    assign strobe_pin = '{cs_n: padin_sram_cs_n, oe_n: padin_sram_oe_n,
                          we_n: padin_sram_we_n, ub_n: padin_sram_ub_n,
                          lb_n: padin_sram_lb_n};

    async_sram_responder_sync #(
        .WIDTH   (STROBE_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (STROBE_IDLE)
    ) u_sync_strobe (
        .clk (clk),
        .rst (rst),
        .d   (strobe_pin),
        .q   (strobe_s)
    );

    async_sram_responder_sync #(
        .WIDTH   (DATA_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ('0)
    ) u_sync_data (
        .clk (clk),
        .rst (rst),
        .d   ({padin_sram_a, padin_sram_dq}),
        .q   (data_s)
    );

    assign a_s  = data_s[DATA_W-1 -: N_SRAM_A];
    assign dq_s = data_s[N_SRAM_DQ-1:0];

    // ---------------------------------------------------------------- state
    state_e               state_q,     state_d;
    strobe_t              strobe_p_q,  strobe_p_d;
    logic [N_SRAM_A-1:0]  a_p_q,       a_p_d;
    logic [N_SRAM_DQ-1:0] dq_p_q,      dq_p_d;
    logic                 mem_valid_q, mem_valid_d;
    logic                 mem_write_q, mem_write_d;
    logic [N_SRAM_A-1:0]  mem_addr_q,  mem_addr_d;
    logic [N_SRAM_DQ-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]           mem_wstrb_q, mem_wstrb_d;
    logic [N_SRAM_A-1:0]  rd_addr_q,   rd_addr_d;
    logic                 rd_valid_q,  rd_valid_d;
    logic                 rd_stale_q,  rd_stale_d;
    logic [N_SRAM_DQ-1:0] padout_q,    padout_d;
    logic [N_SRAM_DQ-1:0] padoe_q,     padoe_d;
    logic                 err_q,       err_d;

    logic wr_event;
    logic rd_window;
    logic rd_window_prev;
    logic rd_addr_match;
    logic rd_issue;

    // NOTE: every signal assigned here gets its default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        // Write edge: WE_n was low under CS_n in the previous sample, high now.
        wr_event       = !strobe_p_q.cs_n && !strobe_p_q.we_n && strobe_s.we_n;
        rd_window      = !strobe_s.cs_n && !strobe_s.oe_n && strobe_s.we_n;
        rd_window_prev = !strobe_p_q.cs_n && !strobe_p_q.oe_n && strobe_p_q.we_n;
        rd_addr_match  = (a_s == rd_addr_q);
        rd_issue       = (state_q == ST_IDLE) && !wr_event && rd_window &&
                         (!rd_window_prev || !rd_addr_match || !rd_valid_q);

        state_d     = state_q;
        strobe_p_d  = strobe_s;
        a_p_d       = a_s;
        dq_p_d      = dq_s;
        mem_valid_d = mem_valid_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rd_addr_d   = rd_addr_q;
        rd_valid_d  = rd_valid_q;
        rd_stale_d  = rd_stale_q;
        padout_d    = padout_q;
        err_d       = err_q | (wr_event && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (wr_event) begin
                    // Capture from the last sample taken while WE_n was low.
                    state_d     = ST_WR_REQ;
                    mem_valid_d = 1'b1;
                    mem_write_d = 1'b1;
                    mem_addr_d  = a_p_q;
                    mem_wdata_d = dq_p_q;
                    mem_wstrb_d = lane_strb(strobe_p_q.ub_n, strobe_p_q.lb_n);
                    // Held read data may now be out of date.
                    rd_valid_d  = 1'b0;
                end else if (rd_issue) begin
                    state_d     = ST_RD_REQ;
                    mem_valid_d = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = a_s;
                    mem_wdata_d = '0;
                    mem_wstrb_d = 2'b00;
                    rd_addr_d   = a_s;
                    rd_valid_d  = 1'b0;
                    rd_stale_d  = 1'b0;
                end
            end
            ST_WR_REQ: begin
                if (mem_ready) begin
                    state_d     = ST_IDLE;
                    mem_valid_d = 1'b0;
                end
            end
            ST_RD_REQ: begin
                if (mem_ready) begin
                    state_d     = ST_RD_WAIT;
                    mem_valid_d = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) begin
                    state_d    = ST_IDLE;
                    padout_d   = mem_rdata;
                    // Only keep the data if the host is still reading that address.
                    rd_valid_d = !rd_stale_q && rd_window && rd_addr_match;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A window that closes or moves while the read is in flight makes the
        // returned data useless, even if the pins come back before it lands.
        if ((state_q == ST_RD_REQ || state_q == ST_RD_WAIT) &&
            !(rd_window && rd_addr_match)) begin
            rd_stale_d = 1'b1;
        end

        // Drive only valid data for the address currently on the pins; an
        // issue clears rd_valid_d, so padoe drops in the issue cycle.
        padoe_d = (rd_window && rd_valid_d && rd_addr_match)
                  ? lane_oe(strobe_s.ub_n, strobe_s.lb_n) : '0;
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            strobe_p_q  <= STROBE_IDLE;
            a_p_q       <= '0;
            dq_p_q      <= '0;
            mem_valid_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 2'b00;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_stale_q  <= 1'b0;
            padout_q    <= '0;
            padoe_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            strobe_p_q  <= strobe_p_d;
            a_p_q       <= a_p_d;
            dq_p_q      <= dq_p_d;
            mem_valid_q <= mem_valid_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rd_addr_q   <= rd_addr_d;
            rd_valid_q  <= rd_valid_d;
            rd_stale_q  <= rd_stale_d;
            padout_q    <= padout_d;
            padoe_q     <= padoe_d;
            err_q       <= err_d;
        end
    end

    assign padout_sram_dq = padout_q;
    assign padoe_sram_dq  = padoe_q;
    assign mem_valid      = mem_valid_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wstrb      = mem_wstrb_q;
    assign err_overrun    = err_q;

endmodule

// File: tb/tb_async_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_async_sram_responder
// Directed bench for async_sram_responder: a table of pin-level writes with
// hand-computed requests, then hand-written read, address-change, backpressure
// and reset sequences.
// -----------------------------------------------------------------------------
module tb_async_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] pin_a;
    logic [15:0] pin_dq;
    logic        pin_cs_n, pin_oe_n, pin_we_n, pin_ub_n, pin_lb_n;
    logic [15:0] padout_sram_dq, padoe_sram_dq;
    logic        mem_valid, mem_ready, mem_write;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        err_overrun;

    always #5 clk = ~clk;

    async_sram_responder dut (
        .clk             (clk),
        .rst             (rst),
        .padin_sram_a    (pin_a),
        .padin_sram_dq   (pin_dq),
        .padin_sram_cs_n (pin_cs_n),
        .padin_sram_oe_n (pin_oe_n),
        .padin_sram_we_n (pin_we_n),
        .padin_sram_ub_n (pin_ub_n),
        .padin_sram_lb_n (pin_lb_n),
        .padout_sram_dq  (padout_sram_dq),
        .padoe_sram_dq   (padoe_sram_dq),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .err_overrun     (err_overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Accepted-request log.
    int          n_acc = 0;
    logic        last_write;
    logic [17:0] last_addr;
    logic [15:0] last_wdata;
    logic [1:0]  last_wstrb;

    always @(posedge clk) begin
        if (mem_valid && mem_ready) begin
            n_acc      <= n_acc + 1;
            last_write <= mem_write;
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
            last_wstrb <= mem_wstrb;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_pulse(input logic [17:0] a, input logic [15:0] dq,
                               input logic ub_n, input logic lb_n);
        pin_a    = a;
        pin_dq   = dq;
        pin_ub_n = ub_n;
        pin_lb_n = lb_n;
        pin_oe_n = 1'b1;
        pin_cs_n = 1'b0;
        cyc(4);
        pin_we_n = 1'b0;
        cyc(6);
        pin_we_n = 1'b1;
        cyc(4);
        pin_cs_n = 1'b1;
        cyc(4);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_valid) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic wait_acc(input int n0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (n_acc > n0) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    // Waits for the read request to be accepted, then returns one data beat.
    task automatic serve_read(input logic [15:0] d, input int n0);
        bit ok;
        wait_acc(n0, ok);
        check("serve_wait", {31'd0, ok}, 32'd1);
        mem_rdata  = d;
        mem_rvalid = 1'b1;
        cyc();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    typedef struct {
        logic [17:0] a;
        logic [15:0] dq;
        logic        ub_n;
        logic        lb_n;
        logic [17:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [1:0]  exp_wstrb;
    } wr_vec_t;

    wr_vec_t vecs[4];
    int      unstable = 0;
    logic [37:0] snap;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n0, n1, n2;

        vecs[0] = '{18'h01234, 16'hBEEF, 1'b0, 1'b0, 18'h01234, 16'hBEEF, 2'b11};
        vecs[1] = '{18'h01234, 16'h00A5, 1'b1, 1'b0, 18'h01234, 16'h00A5, 2'b01};
        vecs[2] = '{18'h3FFFF, 16'hA500, 1'b0, 1'b1, 18'h3FFFF, 16'hA500, 2'b10};
        vecs[3] = '{18'h00000, 16'hFFFF, 1'b1, 1'b1, 18'h00000, 16'hFFFF, 2'b00};

        rst        = 1'b1;
        pin_a      = '0;
        pin_dq     = '0;
        pin_cs_n   = 1'b1;
        pin_oe_n   = 1'b1;
        pin_we_n   = 1'b1;
        pin_ub_n   = 1'b0;
        pin_lb_n   = 1'b0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        cyc(3);
        check("rst_valid",  {31'd0, mem_valid},   32'd0);
        check("rst_padoe",  {16'd0, padoe_sram_dq},  32'd0);
        check("rst_padout", {16'd0, padout_sram_dq}, 32'd0);
        check("rst_err",    {31'd0, err_overrun}, 32'd0);
        rst = 1'b0;
        cyc(5);

        // Pin-level writes, one request each.
        for (int i = 0; i < 4; i++) begin
            n0 = n_acc;
            write_pulse(vecs[i].a, vecs[i].dq, vecs[i].ub_n, vecs[i].lb_n);
            cyc(2);
            check($sformatf("wr%0d_count", i), n_acc - n0, 32'd1);
            check($sformatf("wr%0d_write", i), {31'd0, last_write}, 32'd1);
            check($sformatf("wr%0d_addr",  i), {14'd0, last_addr},  {14'd0, vecs[i].exp_addr});
            check($sformatf("wr%0d_wdata", i), {16'd0, last_wdata}, {16'd0, vecs[i].exp_wdata});
            check($sformatf("wr%0d_wstrb", i), {30'd0, last_wstrb}, {30'd0, vecs[i].exp_wstrb});
        end
        check("wr_no_overrun", {31'd0, err_overrun}, 32'd0);

        // Read at the top address with a stalled accept.
        mem_ready = 1'b0;
        pin_a     = 18'h3FFFF;
        pin_ub_n  = 1'b0;
        pin_lb_n  = 1'b0;
        n0        = n_acc;
        pin_cs_n  = 1'b0;
        pin_oe_n  = 1'b0;
        wait_valid(ok);
        check("rd_req_seen",  {31'd0, ok}, 32'd1);
        check("rd_req_write", {31'd0, mem_write}, 32'd0);
        check("rd_req_addr",  {14'd0, mem_addr}, 32'h3FFFF);
        check("rd_req_padoe", {16'd0, padoe_sram_dq}, 32'd0);
        cyc(3);
        check("rd_req_hold",  {31'd0, mem_valid}, 32'd1);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        serve_read(16'h5A5A, n0);
        check("rd_padout", {16'd0, padout_sram_dq}, 32'h5A5A);
        check("rd_padoe",  {16'd0, padoe_sram_dq},  32'hFFFF);
        cyc(5);
        check("rd_drive_hold", {16'd0, padoe_sram_dq}, 32'hFFFF);
        pin_ub_n = 1'b1;
        cyc(4);
        check("rd_lane_lo", {16'd0, padoe_sram_dq}, 32'h00FF);
        pin_ub_n = 1'b0;
        cyc(4);
        pin_oe_n = 1'b1;
        cyc(2);
        check("rd_close_lag", {16'd0, padoe_sram_dq}, 32'hFFFF);
        cyc();
        check("rd_close", {16'd0, padoe_sram_dq}, 32'd0);
        pin_cs_n = 1'b1;
        cyc(5);
        check("rd_single", n_acc - n0, 32'd1);

        // Address change while driving.
        mem_ready = 1'b1;
        pin_a     = 18'h00010;
        n0        = n_acc;
        pin_cs_n  = 1'b0;
        pin_oe_n  = 1'b0;
        serve_read(16'h1111, n0);
        check("chg_padout0", {16'd0, padout_sram_dq}, 32'h1111);
        check("chg_padoe0",  {16'd0, padoe_sram_dq},  32'hFFFF);
        n1 = n_acc;
        check("chg_count0", n1 - n0, 32'd1);
        pin_a = 18'h00011;
        cyc(3);
        check("chg_padoe_drop", {16'd0, padoe_sram_dq}, 32'd0);
        check("chg_valid",      {31'd0, mem_valid}, 32'd1);
        check("chg_addr",       {14'd0, mem_addr}, 32'h11);
        serve_read(16'h2222, n1);
        check("chg_padout1",    {16'd0, padout_sram_dq}, 32'h2222);
        check("chg_padoe1",     {16'd0, padoe_sram_dq},  32'hFFFF);
        check("chg_last_addr",  {14'd0, last_addr}, 32'h11);
        pin_oe_n = 1'b1;
        pin_cs_n = 1'b1;
        cyc(6);

        // Backpressure on a write with a second pulse during the stall.
        mem_ready = 1'b0;
        n0        = n_acc;
        write_pulse(18'h00055, 16'h1234, 1'b0, 1'b0);
        wait_valid(ok);
        check("bp_valid", {31'd0, ok}, 32'd1);
        snap = {mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb};
        fork
            write_pulse(18'h00066, 16'h9999, 1'b0, 1'b0);
            begin
                for (int i = 0; i < 20; i++) begin
                    cyc();
                    if ({mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb} !== snap)
                        unstable++;
                end
            end
        join
        check("bp_stable",  unstable, 32'd0);
        check("bp_overrun", {31'd0, err_overrun}, 32'd1);
        check("bp_none_yet", n_acc - n0, 32'd0);
        mem_ready = 1'b1;
        cyc(5);
        check("bp_count", n_acc - n0, 32'd1);
        check("bp_addr",  {14'd0, last_addr},  32'h55);
        check("bp_wdata", {16'd0, last_wdata}, 32'h1234);
        cyc(10);
        check("bp_single", n_acc - n0, 32'd1);

        // Reset while driving, then reset while a read is outstanding.
        pin_a    = 18'h00020;
        n0       = n_acc;
        pin_cs_n = 1'b0;
        pin_oe_n = 1'b0;
        serve_read(16'h3333, n0);
        check("rs_drive", {16'd0, padoe_sram_dq}, 32'hFFFF);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rs_padoe",  {16'd0, padoe_sram_dq},  32'd0);
        check("rs_valid",  {31'd0, mem_valid},      32'd0);
        check("rs_padout", {16'd0, padout_sram_dq}, 32'd0);
        check("rs_err",    {31'd0, err_overrun},    32'd0);
        cyc(2);
        n0  = n_acc;
        rst = 1'b0;
        wait_acc(n0, ok);
        check("rs_reissue", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rs_wait_valid", {31'd0, mem_valid}, 32'd0);
        cyc(2);
        rst        = 1'b0;
        mem_rdata  = 16'hDEAD;
        mem_rvalid = 1'b1;
        cyc();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        check("late_rvalid_out", {16'd0, padout_sram_dq}, 32'd0);
        check("late_rvalid_oe",  {16'd0, padoe_sram_dq},  32'd0);
        n2 = n_acc;
        serve_read(16'h7777, n2);
        check("rs_new_addr",   {14'd0, last_addr}, 32'h20);
        check("rs_new_padout", {16'd0, padout_sram_dq}, 32'h7777);
        check("rs_new_padoe",  {16'd0, padoe_sram_dq},  32'hFFFF);
        pin_oe_n = 1'b1;
        pin_cs_n = 1'b1;
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
